// File: rtl/sme_pkg.sv
// -----------------------------------------------------------------------------
// sme_pkg
// Shared definitions for the sme_multi string-match engine.
//   CH_DOT / CH_CARET / CH_DOLLAR : pattern metacharacters ('.', '^', '$')
//   CH_SPACE                      : word separator used by the '^' and '$' anchors
//   state_t                       : control FSM states
//   elem_t                        : kind of pattern element being evaluated
// -----------------------------------------------------------------------------
package sme_pkg;

    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        RD_STR,
        RD_PAT,
        SCAN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        LIT,
        ANY,
        BOL,
        EOL
    } elem_t;

endpackage

// File: rtl/sme_char_cmp.sv
// -----------------------------------------------------------------------------
// sme_char_cmp
// Combinational evaluator for one pattern element at one string position.
// Optional build macro: CASE_FOLD_EN (literal compares fold ASCII A-Z onto a-z).
// Ports:
//   pat_char  : pattern element (anchors recognised on low 8 bits, zero-extended)
//   str_char  : string char at pos
//   prev_char : string char at pos-1 (only meaningful when pos > 0)
//   pos       : current string position
//   len_s     : stored string length
//   hit       : element is true at pos
//   consume   : element advances the string position when it hits
// -----------------------------------------------------------------------------
module sme_char_cmp
    import sme_pkg::*;
#(
    parameter int CHAR_W = 8,
    parameter int LEN_W  = 6
) (
    input  logic [CHAR_W-1:0] pat_char,
    input  logic [CHAR_W-1:0] str_char,
    input  logic [CHAR_W-1:0] prev_char,
    input  logic [LEN_W-1:0]  pos,
    input  logic [LEN_W-1:0]  len_s,
    output logic              hit,
    output logic              consume
);

    elem_t elem;
    logic  in_range;
    logic  lit_eq;

`ifdef CASE_FOLD_EN
    // Upper-case letters are mapped onto lower case so that literal compares
    // ignore case; everything else passes through untouched.
    function automatic logic [CHAR_W-1:0] fold_case(input logic [CHAR_W-1:0] c);
        if (c >= CHAR_W'(8'h41) && c <= CHAR_W'(8'h5A)) begin
            return c | CHAR_W'(8'h20);
        end
        return c;
    endfunction

    assign lit_eq = (fold_case(pat_char) == fold_case(str_char));
`else
    assign lit_eq = (pat_char == str_char);
`endif

    assign in_range = (pos < len_s);

    // Classify the pattern element, then decide whether it holds at pos.
    // Anchors never consume a char; '.' and literals need a real char at pos,
    // so they fail once pos reaches the end of the stored string.
    always_comb begin
        elem    = LIT;
        hit     = 1'b0;
        consume = 1'b1;
        if (pat_char == CHAR_W'(CH_DOT)) begin
            elem = ANY;
        end else if (pat_char == CHAR_W'(CH_CARET)) begin
            elem = BOL;
        end else if (pat_char == CHAR_W'(CH_DOLLAR)) begin
            elem = EOL;
        end
        case (elem)
            ANY: begin
                hit = in_range;
            end
            BOL: begin
                consume = 1'b0;
                hit     = (pos == '0) || (prev_char == CHAR_W'(CH_SPACE));
            end
            EOL: begin
                consume = 1'b0;
                hit     = (pos == len_s) || (in_range && (str_char == CHAR_W'(CH_SPACE)));
            end
            default: begin
                hit = in_range && lit_eq;
            end
        endcase
    end

endmodule

// File: rtl/sme_multi.sv
// -----------------------------------------------------------------------------
// sme_multi
// Streaming string-match engine: buffers a string and a pattern, then tries
// every start position 0..len_s in order, one pattern element per cycle.
// The string is kept across patterns, so several patterns can be matched
// against one string. Optional build macro: CASE_FOLD_EN (see sme_char_cmp).
// Ports:
//   clk         : rising-edge clock
//   reset       : synchronous, active-low reset
//   chardata    : string or pattern char
//   isstring    : string char valid this cycle
//   ispattern   : pattern char valid this cycle (wins over isstring)
//   valid       : one-cycle pulse, result fields updated
//   match       : at least one start position matched
//   match_index : lowest matching start position (0 if none)
//   match_count : number of matching start positions
//   busy        : scan in progress or result being reported; inputs ignored
// -----------------------------------------------------------------------------
module sme_multi
    import sme_pkg::*;
#(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int CHAR_W  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHAR_W-1:0]            chardata,
    input  logic                         isstring,
    input  logic                         ispattern,
    output logic                         valid,
    output logic                         match,
    output logic [$clog2(STR_MAX)-1:0]   match_index,
    output logic [$clog2(STR_MAX+1)-1:0] match_count,
    output logic                         busy
);

    localparam int IDX_W = $clog2(STR_MAX);
    localparam int LEN_W = $clog2(STR_MAX + 1);
    localparam int PI_W  = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
    localparam int PL_W  = $clog2(PAT_MAX + 1);

    state_t            state;
    logic [CHAR_W-1:0] buf_s [STR_MAX];
    logic [CHAR_W-1:0] buf_p [PAT_MAX];
    logic [LEN_W-1:0]  len_s;
    logic [PL_W-1:0]   len_p;

    logic [LEN_W-1:0]  s_start;
    logic [LEN_W-1:0]  pos;
    logic [PI_W-1:0]   k;
    logic              scan_found;
    logic [IDX_W-1:0]  scan_index;
    logic [LEN_W-1:0]  scan_count;

    logic              take_str;
    logic              take_pat;
    logic [LEN_W-1:0]  str_wr_idx;
    logic [PL_W-1:0]   pat_wr_idx;

    logic [CHAR_W-1:0] pat_char;
    logic [CHAR_W-1:0] str_char;
    logic [CHAR_W-1:0] prev_char;
    logic [IDX_W-1:0]  prev_idx;
    logic              hit;
    logic              consume;
    logic              last_elem;
    logic              last_start;
    logic              scan_empty;
    logic              success;
    logic              start_end;
    logic              found_nxt;
    logic [IDX_W-1:0]  index_nxt;
    logic [LEN_W-1:0]  count_nxt;

    assign prev_idx  = pos[IDX_W-1:0] - IDX_W'(1);
    assign pat_char  = buf_p[k];
    assign str_char  = buf_s[pos[IDX_W-1:0]];
    assign prev_char = buf_s[prev_idx];

    sme_char_cmp #(
        .CHAR_W (CHAR_W),
        .LEN_W  (LEN_W)
    ) u_cmp (
        .pat_char  (pat_char),
        .str_char  (str_char),
        .prev_char (prev_char),
        .pos       (pos),
        .len_s     (len_s),
        .hit       (hit),
        .consume   (consume)
    );

    // Decide which buffer (if any) takes chardata this cycle and where it goes.
    // A load that starts from IDLE restarts at index 0; continuing cycles
    // append at the current length. Nothing is accepted while busy.
    always_comb begin
        take_str   = 1'b0;
        take_pat   = 1'b0;
        str_wr_idx = len_s;
        pat_wr_idx = len_p;
        if (state == IDLE || state == RD_STR || state == RD_PAT) begin
            take_pat = ispattern;
            take_str = isstring && !ispattern && (state != RD_PAT);
        end
        if (state != RD_STR) begin
            str_wr_idx = '0;
        end
        if (state != RD_PAT) begin
            pat_wr_idx = '0;
        end
    end

    // Char buffers carry no reset; only the lengths define what is valid.
    // Writes past the buffer depth are dropped.
    always_ff @(posedge clk) begin
        if (take_str && (str_wr_idx < LEN_W'(STR_MAX))) begin
            buf_s[str_wr_idx[IDX_W-1:0]] <= chardata;
        end
        if (take_pat && (pat_wr_idx < PL_W'(PAT_MAX))) begin
            buf_p[pat_wr_idx[PI_W-1:0]] <= chardata;
        end
    end

    // Scan bookkeeping: a start position ends either on the first false
    // element (abort) or when its last element hits (success). The running
    // result is computed here so the final start can feed the outputs in the
    // same cycle it finishes.
    always_comb begin
        last_elem  = ((PL_W'(k) + PL_W'(1)) == len_p);
        last_start = (s_start == len_s);
        scan_empty = (len_s == '0) || (len_p == '0);
        success    = hit && last_elem;
        start_end  = !hit || last_elem;
        found_nxt  = scan_found;
        index_nxt  = scan_index;
        count_nxt  = scan_count;
        if (success) begin
            count_nxt = scan_count + LEN_W'(1);
            if (!scan_found) begin
                found_nxt = 1'b1;
                index_nxt = IDX_W'(s_start);
            end
        end
    end

    // Control FSM with registered outputs. Lengths saturate at the buffer
    // depths. busy is raised on entry to SCAN and dropped when DONE exits;
    // result fields are only updated on entry to DONE and then held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            len_s       <= '0;
            len_p       <= '0;
            s_start     <= '0;
            pos         <= '0;
            k           <= '0;
            scan_found  <= 1'b0;
            scan_index  <= '0;
            scan_count  <= '0;
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
            match_count <= '0;
            busy        <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ispattern) begin
                        state <= RD_PAT;
                        len_p <= PL_W'(1);
                    end else if (isstring) begin
                        state <= RD_STR;
                        len_s <= LEN_W'(1);
                    end
                end
                RD_STR: begin
                    if (ispattern) begin
                        state <= RD_PAT;
                        len_p <= PL_W'(1);
                    end else if (isstring) begin
                        if (len_s < LEN_W'(STR_MAX)) begin
                            len_s <= len_s + LEN_W'(1);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RD_PAT: begin
                    if (ispattern) begin
                        if (len_p < PL_W'(PAT_MAX)) begin
                            len_p <= len_p + PL_W'(1);
                        end
                    end else begin
                        state      <= SCAN;
                        busy       <= 1'b1;
                        s_start    <= '0;
                        pos        <= '0;
                        k          <= '0;
                        scan_found <= 1'b0;
                        scan_index <= '0;
                        scan_count <= '0;
                    end
                end
                SCAN: begin
                    if (scan_empty) begin
                        state       <= DONE;
                        valid       <= 1'b1;
                        match       <= 1'b0;
                        match_index <= '0;
                        match_count <= '0;
                    end else if (start_end) begin
                        scan_found <= found_nxt;
                        scan_index <= index_nxt;
                        scan_count <= count_nxt;
                        if (last_start) begin
                            state       <= DONE;
                            valid       <= 1'b1;
                            match       <= found_nxt;
                            match_index <= index_nxt;
                            match_count <= count_nxt;
                        end else begin
                            s_start <= s_start + LEN_W'(1);
                            pos     <= s_start + LEN_W'(1);
                            k       <= '0;
                        end
                    end else begin
                        k <= k + PI_W'(1);
                        if (consume) begin
                            pos <= pos + LEN_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_multi.sv
// -----------------------------------------------------------------------------
// tb_sme_multi
// Self-checking bench for sme_multi (default parameters). Expected results are
// queued when a pattern is sent and popped when the DUT pulses valid.
// Honours CASE_FOLD_EN to pick the expected result of the case-fold scenario.
// -----------------------------------------------------------------------------
module tb_sme_multi;

    localparam int IW = 5;
    localparam int CW = 6;

    logic          clk;
    logic          reset;
    logic [7:0]    chardata;
    logic          isstring;
    logic          ispattern;
    logic          valid;
    logic          match;
    logic [IW-1:0] match_index;
    logic [CW-1:0] match_count;
    logic          busy;

    sme_multi #(
        .STR_MAX (32),
        .PAT_MAX (8),
        .CHAR_W  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .valid       (valid),
        .match       (match),
        .match_index (match_index),
        .match_count (match_count),
        .busy        (busy)
    );

    typedef struct packed {
        logic          m;
        logic [IW-1:0] idx;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          cur;
    int            checks = 0;
    int            failures = 0;
    logic          got_valid;
    logic          one_shot;
    logic          r_m;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    int            lat;

    // Free-running 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic send_string(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk); #1;
            isstring = 1'b1;
            chardata = s[i];
        end
        @(posedge clk); #1;
        isstring = 1'b0;
    endtask

    // Sends a pattern, then waits (bounded) for the valid pulse and captures
    // the result. When poke is set, isstring is held high with junk while busy.
    task automatic run_pattern(input string p, input bit poke);
        for (int i = 0; i < p.len(); i++) begin
            @(posedge clk); #1;
            ispattern = 1'b1;
            chardata  = p[i];
        end
        @(posedge clk); #1;
        ispattern = 1'b0;
        got_valid = 1'b0;
        one_shot  = 1'b0;
        r_m       = 1'bx;
        r_idx     = 'x;
        r_cnt     = 'x;
        lat       = 0;
        while (!got_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (poke) begin
                isstring = 1'b1;
                chardata = 8'h7A;
            end
            if (valid === 1'b1) begin
                got_valid = 1'b1;
                r_m       = match;
                r_idx     = match_index;
                r_cnt     = match_count;
            end
        end
        isstring = 1'b0;
        @(posedge clk); #1;
        one_shot = (valid === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (match !== 1'b0) begin failures++; $display("[TB] FAIL reset_match: got %b expected 0", match); end
        checks++; if (match_index !== '0) begin failures++; $display("[TB] FAIL reset_index: got %0d expected 0", match_index); end
        checks++; if (match_count !== '0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", match_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        send_string("hello world");
        exp_q.push_back('{m: 1'b1, idx: 5'd6, cnt: 6'd1});
        run_pattern("wor", 1'b0);
        cur = exp_q.pop_front();
        checks++; if (got_valid !== 1'b1) begin failures++; $display("[TB] FAIL wor_valid: got no valid in %0d cycles, expected a pulse", lat); end
        checks++; if (one_shot !== 1'b1) begin failures++; $display("[TB] FAIL wor_pulse: valid still high next cycle, expected one-cycle pulse"); end
        checks++; if (r_m !== cur.m) begin failures++; $display("[TB] FAIL wor_match: got %b expected %b", r_m, cur.m); end
        checks++; if (r_idx !== cur.idx) begin failures++; $display("[TB] FAIL wor_index: got %0d expected %0d", r_idx, cur.idx); end
        checks++; if (r_cnt !== cur.cnt) begin failures++; $display("[TB] FAIL wor_count: got %0d expected %0d", r_cnt, cur.cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL wor_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_reuse();
        exp_q.push_back('{m: 1'b1, idx: 5'd4, cnt: 6'd2});
        run_pattern("o", 1'b0);
        cur = exp_q.pop_front();
        checks++; if (got_valid !== 1'b1) begin failures++; $display("[TB] FAIL reuse_valid: got no valid, expected a pulse"); end
        checks++; if (r_m !== cur.m) begin failures++; $display("[TB] FAIL reuse_match: got %b expected %b", r_m, cur.m); end
        checks++; if (r_idx !== cur.idx) begin failures++; $display("[TB] FAIL reuse_index: got %0d expected %0d", r_idx, cur.idx); end
        checks++; if (r_cnt !== cur.cnt) begin failures++; $display("[TB] FAIL reuse_count: got %0d expected %0d", r_cnt, cur.cnt); end
    endtask

    task automatic test_anchor_bol();
        send_string("hello world");
        exp_q.push_back('{m: 1'b1, idx: 5'd6, cnt: 6'd1});
        exp_q.push_back('{m: 1'b0, idx: 5'd0, cnt: 6'd0});
        run_pattern("^wo", 1'b0);
        cur = exp_q.pop_front();
        checks++; if ({r_m, r_idx, r_cnt} !== {cur.m, cur.idx, cur.cnt}) begin failures++; $display("[TB] FAIL bol_wo: got m=%b i=%0d c=%0d expected m=%b i=%0d c=%0d", r_m, r_idx, r_cnt, cur.m, cur.idx, cur.cnt); end
        run_pattern("^el", 1'b0);
        cur = exp_q.pop_front();
        checks++; if (got_valid !== 1'b1) begin failures++; $display("[TB] FAIL bol_el_valid: got no valid, expected a pulse"); end
        checks++; if ({r_m, r_idx, r_cnt} !== {cur.m, cur.idx, cur.cnt}) begin failures++; $display("[TB] FAIL bol_el: got m=%b i=%0d c=%0d expected m=%b i=%0d c=%0d", r_m, r_idx, r_cnt, cur.m, cur.idx, cur.cnt); end
    endtask

    task automatic test_anchor_eol();
        send_string("ab cab");
        exp_q.push_back('{m: 1'b1, idx: 5'd0, cnt: 6'd2});
        exp_q.push_back('{m: 1'b0, idx: 5'd0, cnt: 6'd0});
        run_pattern("ab$", 1'b0);
        cur = exp_q.pop_front();
        checks++; if ({r_m, r_idx, r_cnt} !== {cur.m, cur.idx, cur.cnt}) begin failures++; $display("[TB] FAIL eol_ab: got m=%b i=%0d c=%0d expected m=%b i=%0d c=%0d", r_m, r_idx, r_cnt, cur.m, cur.idx, cur.cnt); end
        run_pattern("a.b", 1'b0);
        cur = exp_q.pop_front();
        checks++; if ({r_m, r_idx, r_cnt} !== {cur.m, cur.idx, cur.cnt}) begin failures++; $display("[TB] FAIL dot_a_b: got m=%b i=%0d c=%0d expected m=%b i=%0d c=%0d", r_m, r_idx, r_cnt, cur.m, cur.idx, cur.cnt); end
    endtask

    task automatic test_busy_ignore();
        exp_q.push_back('{m: 1'b1, idx: 5'd0, cnt: 6'd2});
        exp_q.push_back('{m: 1'b1, idx: 5'd3, cnt: 6'd1});
        run_pattern("ab$", 1'b1);
        cur = exp_q.pop_front();
        checks++; if ({r_m, r_idx, r_cnt} !== {cur.m, cur.idx, cur.cnt}) begin failures++; $display("[TB] FAIL busy_scan: got m=%b i=%0d c=%0d expected m=%b i=%0d c=%0d", r_m, r_idx, r_cnt, cur.m, cur.idx, cur.cnt); end
        run_pattern("cab", 1'b0);
        cur = exp_q.pop_front();
        checks++; if ({r_m, r_idx, r_cnt} !== {cur.m, cur.idx, cur.cnt}) begin failures++; $display("[TB] FAIL busy_string_kept: got m=%b i=%0d c=%0d expected m=%b i=%0d c=%0d", r_m, r_idx, r_cnt, cur.m, cur.idx, cur.cnt); end
    endtask

    task automatic test_empty_tail();
        send_string("ab");
        exp_q.push_back('{m: 1'b1, idx: 5'd2, cnt: 6'd1});
        run_pattern("$", 1'b0);
        cur = exp_q.pop_front();
        checks++; if ({r_m, r_idx, r_cnt} !== {cur.m, cur.idx, cur.cnt}) begin failures++; $display("[TB] FAIL eol_tail: got m=%b i=%0d c=%0d expected m=%b i=%0d c=%0d", r_m, r_idx, r_cnt, cur.m, cur.idx, cur.cnt); end
    endtask

    task automatic test_saturation();
        send_string("abcdefghijklmnopqrstabcdefghijklxyzpqrst");
        exp_q.push_back('{m: 1'b0, idx: 5'd0, cnt: 6'd0});
        exp_q.push_back('{m: 1'b1, idx: 5'd31, cnt: 6'd1});
        run_pattern("xyz", 1'b0);
        cur = exp_q.pop_front();
        checks++; if (got_valid !== 1'b1 || lat > 134) begin failures++; $display("[TB] FAIL sat_latency: got valid=%b after %0d cycles, expected valid within 134", got_valid, lat); end
        checks++; if ({r_m, r_idx, r_cnt} !== {cur.m, cur.idx, cur.cnt}) begin failures++; $display("[TB] FAIL sat_xyz: got m=%b i=%0d c=%0d expected m=%b i=%0d c=%0d", r_m, r_idx, r_cnt, cur.m, cur.idx, cur.cnt); end
        run_pattern("l$", 1'b0);
        cur = exp_q.pop_front();
        checks++; if ({r_m, r_idx, r_cnt} !== {cur.m, cur.idx, cur.cnt}) begin failures++; $display("[TB] FAIL sat_len: got m=%b i=%0d c=%0d expected m=%b i=%0d c=%0d", r_m, r_idx, r_cnt, cur.m, cur.idx, cur.cnt); end
    endtask

    task automatic test_reset_mid_scan();
        logic seen;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ispattern = 1'b1;
            chardata  = 8'h78 + 8'(i);
        end
        @(posedge clk); #1;
        ispattern = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midscan_busy: got %b expected 1", busy); end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        checks++; if ({valid, match, match_index, match_count, busy} !== '0) begin failures++; $display("[TB] FAIL midscan_clear: got v=%b m=%b i=%0d c=%0d b=%b expected all 0", valid, match, match_index, match_count, busy); end
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL midscan_no_valid: got valid pulse after reset, expected none"); end
    endtask

    task automatic test_empty_string();
        exp_q.push_back('{m: 1'b0, idx: 5'd0, cnt: 6'd0});
        run_pattern("a", 1'b0);
        cur = exp_q.pop_front();
        checks++; if (got_valid !== 1'b1) begin failures++; $display("[TB] FAIL empty_valid: got no valid, expected a pulse"); end
        checks++; if ({r_m, r_idx, r_cnt} !== {cur.m, cur.idx, cur.cnt}) begin failures++; $display("[TB] FAIL empty_result: got m=%b i=%0d c=%0d expected m=%b i=%0d c=%0d", r_m, r_idx, r_cnt, cur.m, cur.idx, cur.cnt); end
    endtask

    task automatic test_case_fold();
        send_string("Hello");
`ifdef CASE_FOLD_EN
        exp_q.push_back('{m: 1'b1, idx: 5'd0, cnt: 6'd1});
`else
        exp_q.push_back('{m: 1'b0, idx: 5'd0, cnt: 6'd0});
`endif
        run_pattern("hEL", 1'b0);
        cur = exp_q.pop_front();
        checks++; if ({r_m, r_idx, r_cnt} !== {cur.m, cur.idx, cur.cnt}) begin failures++; $display("[TB] FAIL case_fold: got m=%b i=%0d c=%0d expected m=%b i=%0d c=%0d", r_m, r_idx, r_cnt, cur.m, cur.idx, cur.cnt); end
    endtask

    // Runs every scenario in order, then prints the summary line.
    initial begin
        reset     = 1'b0;
        chardata  = 8'h00;
        isstring  = 1'b0;
        ispattern = 1'b0;
        test_reset();
        test_basic();
        test_reuse();
        test_anchor_bol();
        test_anchor_eol();
        test_busy_ignore();
        test_empty_tail();
        test_saturation();
        test_reset_mid_scan();
        test_empty_string();
        test_case_fold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sme_multi.md
Name: sme_multi

Overview:
- Parametrised string-match engine, the successor of the single-shot 32-char/8-char matcher.
- Buffers a streamed string and a streamed pattern, then scans every start position in order.
- Reports first-match position and total number of matching start positions.
- Generalised in string/pattern depth and char width; a string is retained across several patterns.

Parameters:
STR_MAX, 32, max string length in chars (power of 2, >=2)
PAT_MAX, 8, max pattern length in chars incl. anchors
CHAR_W, 8, bits per char (>=7; anchors compared on low 8 bits zero-extended)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
chardata  input  CHAR_W  char for string or pattern, sampled when isstring or ispattern is high
isstring  input  1  high on consecutive cycles while string chars are delivered
ispattern  input  1  high on consecutive cycles while pattern chars are delivered
valid  output  1  one-cycle pulse, result fields valid
match  output  1  at least one start position matched
match_index  output  $clog2(STR_MAX)  lowest matching start position, 0 if none
match_count  output  $clog2(STR_MAX+1)  number of matching start positions
busy  output  1  high in SCAN/DONE; inputs ignored

Behaviour:
- Reset (reset==0 at clk edge):
  - outputs valid/match/match_index/match_count/busy = 0.
  - FSM -> IDLE; len_s = len_p = 0; buffers need not clear.
- FSM transitions:
  - IDLE -> RD_STR when isstring; -> RD_PAT when ispattern.
  - RD_STR -> RD_PAT when ispattern; stays while isstring; -> IDLE if both low.
  - RD_PAT -> SCAN on first cycle ispattern low.
  - SCAN -> DONE after last start position evaluated.
  - DONE -> IDLE after one cycle; valid=1 in DONE only.
- Loading:
  - first isstring cycle after IDLE/DONE restarts string at index 0; each cycle writes buf_s[len_s], len_s++.
  - chars beyond STR_MAX dropped, len_s saturates.
  - pattern likewise into buf_p/len_p, saturating at PAT_MAX.
  - pattern with no preceding string reuses last stored string.
  - len_s==0 or len_p==0: SCAN ends immediately, match=0.
- Pattern semantics, evaluated at start s:
  - '.' (0x2E) matches any one string char.
  - '^' (0x5E) consumes nothing; true iff current pos==0 or buf_s[pos-1]==0x20.
  - '$' (0x24) consumes nothing; true iff pos==len_s or buf_s[pos]==0x20.
  - Literal char matches iff equal and pos<len_s.
  - Pattern succeeds when all len_p elements true.
  - start s ranges 0..len_s (s==len_s allows "$"/"^$" on empty tail).
- Scan:
  - one pattern element per cycle; abort on first false element; s increments on success or abort.
  - latency from ispattern fall to valid <= (len_s+1)*(len_p+1)+2 cycles.
- Results:
  - match_index = lowest successful s; match_count counts successful s (overlaps counted).
  - outputs held from DONE until next DONE or reset; valid alone pulses.
- isstring/ispattern while busy: ignored, no state change.
- Both isstring and ispattern high in the same cycle: ispattern wins.
- Reset mid-SCAN: aborts scan, no valid pulse.

Optional Feature:
- Macro CASE_FOLD_EN.
- Defined: literal comparison folds ASCII A-Z/a-z (0x41-0x5A ≡ 0x61-0x7A); anchors and '.' unchanged.
- Undefined: exact compare of all CHAR_W bits.

Decomposition:
- Package sme_pkg:
  - CH_DOT, CH_CARET, CH_DOLLAR, CH_SPACE constants.
  - FSM state enum (IDLE, RD_STR, RD_PAT, SCAN, DONE).
  - elem-type enum (LIT, ANY, BOL, EOL).
- Sub-module sme_char_cmp: combinational element evaluator.
  - inputs: pattern char, string char, prev char, pos, len_s.
  - outputs: hit and consume; case fold lives here.

Test Plan:
- string "hello world", pattern "wor" -> valid 1 cycle, match=1, index=6, count=1.
- same string reused, pattern "o" (no new string) -> match=1, index=4, count=2.
- string "hello world", pattern "^wo" -> match=1, index=6, count=1; pattern "^el" -> match=0, index=0, count=0.
- string "ab cab", pattern "ab$" -> match=1, index=0, count=2; pattern "a.b" -> match=0.
- 40-char string, pattern "xyz" -> len_s saturates 32, match=0, valid within 134 cycles; reset low mid-SCAN -> no valid, all outputs 0.
- CASE_FOLD_EN: string "Hello", pattern "hEL" -> match=1, index=0; without macro -> match=0.
